key_bank: RTL and testbench

Parametrised multi-channel push-button processor for the stopwatch and later lab designs. Each of N_KEYS raw button inputs goes through a synchroniser and a per-channel debounce filter. The block then produces three single-cycle event pulses per channel (press, release, long-press) and a start/stop toggle level that software or other logic can clear. It sits between the board buttons and the control logic, replacing ad-hoc per-button edge detectors.

---
 rtl/key_bank_pkg.sv | 35 +++
 rtl/key_bank_chan.sv | 101 ++++++++++
 rtl/key_bank.sv | 42 ++++
 tb/tb_key_bank.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_bank_pkg.sv
// Shared definitions for the push-button bank: width helper, board and
// simulation timing constants, and the per-channel output bundle.
package key_bank_pkg;

  // Debounce and long-press timing for the 100 MHz board.
  localparam int DEB_CYCLES_BOARD  = 1000;
  localparam int LONG_CYCLES_BOARD = 50000;

  // Shortened timing for simulation.
  localparam int DEB_CYCLES_SIM  = 4;
  localparam int LONG_CYCLES_SIM = 20;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic lng;
    logic tgl;
  } key_evt_t;

  // Smallest n with 2**n >= value.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/key_bank_chan.sv
// One button channel: two-flop synchroniser, debounce filter, press/release
// and long-press pulses, and a clearable start/stop toggle.
module key_bank_chan
  import key_bank_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_BOARD,
  parameter int LONG_CYCLES = LONG_CYCLES_BOARD
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     key_i,
  input  logic     tgl_clr_i,
  output key_evt_t evt_o
);

  localparam int DW = clog2(DEB_CYCLES);
  localparam int HW = clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 1);

  logic          s1_q, s2_q;
  logic [DW-1:0] deb_q, deb_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
  logic          tgl_q, tgl_d;

  // Next-state logic for debounce, events, hold counter and toggle.
  always_comb begin
    deb_d   = '0;
    level_d = level_q;
    hold_d  = hold_q;
    tgl_d   = tgl_q;

    if (s2_q != level_q) begin
      if (deb_q == DEB_LAST) begin
        level_d = s2_q;
        deb_d   = '0;
      end else begin
        deb_d = deb_q + 1'b1;
      end
    end else begin
      deb_d = '0;
    end

    press_d = level_d & ~level_q;
    rel_d   = ~level_d & level_q;

    // Saturation at HOLD_MAX is what keeps LONG from repeating within one press.
    if (press_d) begin
      hold_d = '0;
    end else if (level_q && (hold_q != HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
    end else begin
      hold_d = hold_q;
    end

    // A release on the same edge the count completes suppresses LONG.
    long_d = level_q & level_d & (hold_q == HOLD_PRE);

    if (tgl_clr_i) begin
      tgl_d = 1'b0;
    end else if (press_d) begin
      tgl_d = ~tgl_q;
    end else begin
      tgl_d = tgl_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      deb_q   <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      tgl_q   <= 1'b0;
    end else begin
      s1_q    <= key_i;
      s2_q    <= s1_q;
      deb_q   <= deb_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      tgl_q   <= tgl_d;
    end
  end

  assign evt_o = {level_q, press_q, rel_q, long_q, tgl_q};

endmodule

// File: rtl/key_bank.sv
// Bank of N_KEYS independent button channels; slices the per-channel
// event bundles onto the flat output ports.
module key_bank
  import key_bank_pkg::*;
#(
  parameter int N_KEYS      = 4,
  parameter int DEB_CYCLES  = DEB_CYCLES_BOARD,
  parameter int LONG_CYCLES = LONG_CYCLES_BOARD
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_KEYS-1:0] KEY,
  input  logic [N_KEYS-1:0] TGL_CLR,
  output logic [N_KEYS-1:0] LEVEL,
  output logic [N_KEYS-1:0] PRESS,
  output logic [N_KEYS-1:0] RELEASE,
  output logic [N_KEYS-1:0] LONG,
  output logic [N_KEYS-1:0] TOGGLE
);

  key_evt_t chan_evt [N_KEYS];

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_bank_chan #(
      .DEB_CYCLES (DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_chan (
      .clk_i    (CLK),
      .rst_i    (RST),
      .key_i    (KEY[g]),
      .tgl_clr_i(TGL_CLR[g]),
      .evt_o    (chan_evt[g])
    );

    assign LEVEL[g]   = chan_evt[g].level;
    assign PRESS[g]   = chan_evt[g].press;
    assign RELEASE[g] = chan_evt[g].rel;
    assign LONG[g]    = chan_evt[g].lng;
    assign TOGGLE[g]  = chan_evt[g].tgl;
  end

endmodule

// File: tb/tb_key_bank.sv
// Directed and randomized stimulus for key_bank, checked every cycle against
// a history-window reference model of the button behaviour.
module tb_key_bank;

  localparam int N    = 4;
  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic         CLK;
  logic         RST;
  logic [N-1:0] KEY, TGL_CLR;
  logic [N-1:0] LEVEL, PRESS, RELEASE, LONG_O, TOGGLE;

  int n_checks = 0;
  int n_fail   = 0;

  key_bank #(.N_KEYS(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
    .CLK(CLK), .RST(RST), .KEY(KEY), .TGL_CLR(TGL_CLR),
    .LEVEL(LEVEL), .PRESS(PRESS), .RELEASE(RELEASE), .LONG(LONG_O), .TOGGLE(TOGGLE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: synchroniser pipeline, per-channel history of synchronised
  // samples since the last level change, and age of the current press.
  logic [N-1:0] m_s1, m_s2, m_lvl, m_tgl;
  logic [31:0]  m_hist [N];
  int           m_since [N];
  int           m_held [N];
  logic [N-1:0] exp_level, exp_press, exp_rel, exp_long, exp_tgl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic s2_eval, new_lvl, stable;
    if (RST) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_tgl = '0;
      for (int c = 0; c < N; c++) begin
        m_hist[c] = '0; m_since[c] = 0; m_held[c] = 0;
      end
      exp_level = '0; exp_press = '0; exp_rel = '0; exp_long = '0; exp_tgl = '0;
      return;
    end
    for (int c = 0; c < N; c++) begin
      s2_eval  = m_s2[c];
      m_s2[c]  = m_s1[c];
      m_s1[c]  = KEY[c];
      m_hist[c] = {m_hist[c][30:0], s2_eval};
      m_since[c]++;
      // Accept a new level once the last DEB samples since the previous change all disagree.
      stable = (m_since[c] >= DEB);
      for (int i = 0; i < DEB; i++) if (m_hist[c][i] == m_lvl[c]) stable = 1'b0;
      new_lvl = stable ? ~m_lvl[c] : m_lvl[c];
      if (stable) m_since[c] = 0;
      exp_press[c] = new_lvl & ~m_lvl[c];
      exp_rel[c]   = ~new_lvl & m_lvl[c];
      exp_long[c]  = 1'b0;
      if (exp_press[c]) begin
        m_held[c] = 0;
      end else if (m_lvl[c] && new_lvl) begin
        m_held[c]++;
        if (m_held[c] == LONG) exp_long[c] = 1'b1;
      end
      if (TGL_CLR[c]) m_tgl[c] = 1'b0;
      else if (exp_press[c]) m_tgl[c] = ~m_tgl[c];
      m_lvl[c] = new_lvl;
    end
    exp_level = m_lvl;
    exp_tgl   = m_tgl;
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    chk("LEVEL", 32'(LEVEL), 32'(exp_level));
    chk("PRESS", 32'(PRESS), 32'(exp_press));
    chk("RELEASE", 32'(RELEASE), 32'(exp_rel));
    chk("LONG", 32'(LONG_O), 32'(exp_long));
    chk("TOGGLE", 32'(TOGGLE), 32'(exp_tgl));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Count edges until the selected event appears on channel ch; -1 if never.
  task automatic wait_evt(input int sel, input int ch, input int limit, output int edges);
    logic hit;
    hit = 1'b0;
    edges = 0;
    while (!hit && edges < limit) begin
      cycle();
      edges++;
      case (sel)
        0: hit = PRESS[ch];
        1: hit = RELEASE[ch];
        default: hit = LONG_O[ch];
      endcase
    end
    if (!hit) edges = -1;
  endtask

  int e, cnt, first;
  int remaining [N];

  initial begin
    KEY = '0; TGL_CLR = '0; RST = 1'b1;
    run(3);
    chk("rst_outs", 32'({LEVEL, PRESS, RELEASE, LONG_O, TOGGLE}), 32'd0);

    // Key held from reset release: PRESS on the 6th edge after first sampling.
    RST = 1'b0; KEY[0] = 1'b1;
    wait_evt(0, 0, 20, e);
    chk("press_lat", 32'(e), 32'd6);
    chk("press_only0", 32'(PRESS), 32'd1);
    cycle();
    chk("press_1cyc", 32'(PRESS[0]), 32'd0);
    chk("tgl_after_press", 32'(TOGGLE[0]), 32'd1);

    // 3-cycle glitch rejected, 4-cycle pulse accepted.
    KEY[1] = 1'b1; run(3); KEY[1] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin cycle(); cnt += int'(PRESS[1]); end
    chk("glitch_press", 32'(cnt), 32'd0);
    chk("glitch_level", 32'(LEVEL[1]), 32'd0);
    KEY[1] = 1'b1; run(4); KEY[1] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin cycle(); cnt += int'(PRESS[1]); end
    chk("min_press", 32'(cnt), 32'd1);
    run(10);

    // Long hold: one LONG exactly LONG edges after PRESS, then one RELEASE.
    KEY[2] = 1'b1;
    wait_evt(0, 2, 20, e);
    cnt = 0; first = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (LONG_O[2]) begin cnt++; if (first == 0) first = i; end
    end
    chk("long_cnt", 32'(cnt), 32'd1);
    chk("long_off", 32'(first), 32'd20);
    KEY[2] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin cycle(); cnt += int'(RELEASE[2]); end
    chk("long_rel", 32'(cnt), 32'd1);

    // Debounced level held for 15 cycles: no LONG.
    KEY[2] = 1'b1;
    wait_evt(0, 2, 20, e);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 9) KEY[2] = 1'b0;
      cycle();
      cnt += int'(LONG_O[2]);
    end
    chk("short_no_long", 32'(cnt), 32'd0);

    // Toggle sequence on channel 0.
    TGL_CLR[0] = 1'b1; cycle(); TGL_CLR[0] = 1'b0;
    chk("tgl_clr", 32'(TOGGLE[0]), 32'd0);
    KEY[0] = 1'b0; run(10);
    KEY[0] = 1'b1; wait_evt(0, 0, 20, e);
    chk("tgl_1", 32'(TOGGLE[0]), 32'd1);
    KEY[0] = 1'b0; run(10);
    KEY[0] = 1'b1; wait_evt(0, 0, 20, e);
    chk("tgl_2", 32'(TOGGLE[0]), 32'd0);
    KEY[0] = 1'b0; run(10);
    KEY[0] = 1'b1; run(5);
    TGL_CLR[0] = 1'b1; cycle(); TGL_CLR[0] = 1'b0;
    chk("clr_press", 32'(PRESS[0]), 32'd1);
    chk("clr_wins", 32'(TOGGLE[0]), 32'd0);
    KEY[0] = 1'b0; run(10);

    // All channels pressed together.
    KEY = '0; run(10);
    KEY = '1;
    wait_evt(0, 0, 20, e);
    chk("press_all", 32'(PRESS), 32'hF);

    // Reset mid-long-count (all held) and mid-debounce (channel 3 released).
    run(10);
    KEY[3] = 1'b0; run(2);
    RST = 1'b1; cycle();
    chk("rst_mid", 32'({LEVEL, PRESS, RELEASE, LONG_O, TOGGLE}), 32'd0);
    RST = 1'b0;
    wait_evt(0, 0, 20, e);
    chk("press_after_rst", 32'(e), 32'd6);
    first = 0;
    for (int i = 1; i <= 25; i++) begin
      cycle();
      if (LONG_O[0] && first == 0) first = i;
    end
    chk("long_after_rst", 32'(first), 32'd20);

    // Randomized phase.
    KEY = '0; run(10);
    for (int c = 0; c < N; c++) remaining[c] = int'($urandom_range(1, 40));
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++) begin
        if (remaining[c] == 0) begin
          KEY[c] = ~KEY[c];
          remaining[c] = int'($urandom_range(1, 40));
        end
        remaining[c]--;
        TGL_CLR[c] = ($urandom_range(0, 9) == 0);
      end
      RST = ($urandom_range(0, 599) == 0);
      cycle();
    end
    RST = 1'b0; TGL_CLR = '0;
    run(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
